datapath_bus: RTL and testbench

Register-and-bus datapath that executes the one-hot strobes issued each cycle by the processor control FSM. Holds PC, AR, IR, AC, R and R1–R4, drives a single shared bus selected by `read_en`, contains the ALU, and interfaces to asynchronous-read instruction and data memories. It returns the opcode and the zero flag that the control FSM uses to choose its next state.

---
 rtl/datapath_bus.sv | 106 ++++++++++
 tb/tb_datapath_bus.sv | 201 ++++++++++++++++++++
 2 files changed

// File: rtl/datapath_bus.sv
// Register-and-bus datapath: PC, AR, IR, AC, R, R1-R4, shared bus and ALU.
// Executes the one-hot strobes issued each cycle by the control FSM.
module datapath_bus #(
  parameter int DW  = 16,
  parameter int OPW = 6
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic [3:0]    read_en,
  input  logic [15:0]   write_en,
  input  logic [15:0]   inc_en,
  input  logic [15:0]   clr_en,
  input  logic [2:0]    alu_op,
  output logic [DW-1:0] im_addr,
  input  logic [DW-1:0] im_rdata,
  output logic [DW-1:0] dm_addr,
  input  logic [DW-1:0] dm_rdata,
  output logic [DW-1:0] dm_wdata,
  output logic          dm_we,
  output logic [OPW-1:0] instruction,
  output logic [DW-1:0] z,
  output logic [DW-1:0] bus
);

  logic [DW-1:0] pc, ar, ir, ac, r;
  logic [DW-1:0] r1, r2, r3, r4;
  logic [DW-1:0] alu;
  logic          unused_strobes;

  always_comb begin
    bus = '0;
    case (read_en)
      4'd1:    bus = pc;
      4'd2:    bus = ar;
      4'd4:    bus = ir >> OPW;
      4'd5:    bus = ac;
      4'd6:    bus = r;
      4'd7:    bus = r1;
      4'd8:    bus = r2;
      4'd9:    bus = r3;
      4'd10:   bus = r4;
      4'd12:   bus = dm_rdata;
      4'd13:   bus = im_rdata;
      default: bus = '0;
    endcase
  end

  // Codes 0 and 5-7 fall through to pass-AC.
  always_comb begin
    alu = ac;
    case (alu_op)
      3'd1:    alu = ac + r;
      3'd2:    alu = ac - r;
      3'd3:    alu = ac * r;
      3'd4:    alu = {ac[DW-2:0], 1'b0};
      default: alu = ac;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc <= '0;
      ar <= '0;
      ir <= '0;
      ac <= '0;
      r  <= '0;
      r1 <= '0;
      r2 <= '0;
      r3 <= '0;
      r4 <= '0;
    end else begin
      if (clr_en[1])        pc <= '0;
      else if (write_en[1]) pc <= bus;
      else if (inc_en[1])   pc <= pc + DW'(1);

      if (clr_en[2])        ar <= '0;
      else if (write_en[2]) ar <= bus;

      if (clr_en[4])         ac <= '0;
      else if (write_en[12]) ac <= alu;
      else if (write_en[4])  ac <= bus;
      else if (inc_en[4])    ac <= ac + DW'(1);

      if (write_en[3])  ir <= bus;
      if (write_en[5])  r  <= bus;
      if (write_en[10]) r1 <= bus;
      if (write_en[9])  r2 <= bus;
      if (write_en[8])  r3 <= bus;
      if (write_en[7])  r4 <= bus;
    end
  end

  assign im_addr     = pc;
  assign dm_addr     = ar;
  assign dm_wdata    = bus;
  assign dm_we       = write_en[11];
  assign instruction = ir[OPW-1:0];
  assign z           = {{(DW-1){1'b0}}, (ac == '0)};

  assign unused_strobes = ^{write_en[15:13], write_en[6],
                            write_en[0], inc_en[15:5],
                            inc_en[3:2], inc_en[0],
                            clr_en[15:5], clr_en[3],
                            clr_en[0]};

endmodule

// File: tb/tb_datapath_bus.sv
// Directed-vector bench for datapath_bus.
// Table of single-cycle ops plus reset and memory-write sequences.
module tb_datapath_bus;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [3:0]  read_en;
  logic [15:0] write_en, inc_en, clr_en;
  logic [2:0]  alu_op;
  logic [15:0] im_addr, im_rdata;
  logic [15:0] dm_addr, dm_rdata, dm_wdata;
  logic        dm_we;
  logic [5:0]  instruction;
  logic [15:0] z, bus;

  int checks = 0;
  int failures = 0;

  datapath_bus #(.DW(16), .OPW(6)) dut (
    .clk(clk), .rst_n(rst_n),
    .read_en(read_en), .write_en(write_en),
    .inc_en(inc_en), .clr_en(clr_en),
    .alu_op(alu_op),
    .im_addr(im_addr), .im_rdata(im_rdata),
    .dm_addr(dm_addr), .dm_rdata(dm_rdata),
    .dm_wdata(dm_wdata), .dm_we(dm_we),
    .instruction(instruction), .z(z), .bus(bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0]  re;
    logic [15:0] we, inc, clr;
    logic [2:0]  op;
    logic [15:0] im, dm;
    logic [3:0]  obs;
    logic [15:0] e_bus, e_pc, e_ar;
    logic [5:0]  e_ins;
    logic        e_z;
  } vec_t;

  vec_t vq[$];

  function automatic logic [15:0] b(input int k);
    logic [15:0] one;
    one = 16'd1;
    return one << k;
  endfunction

  function automatic vec_t mk(
    input logic [3:0] re, input logic [15:0] we,
    input logic [15:0] inc, input logic [15:0] clr,
    input logic [2:0] op, input logic [15:0] im,
    input logic [15:0] dm, input logic [3:0] obs,
    input logic [15:0] e_bus, input logic [15:0] e_pc,
    input logic [15:0] e_ar, input logic [5:0] e_ins,
    input logic e_z);
    vec_t v;
    v.re = re; v.we = we; v.inc = inc; v.clr = clr;
    v.op = op; v.im = im; v.dm = dm; v.obs = obs;
    v.e_bus = e_bus; v.e_pc = e_pc; v.e_ar = e_ar;
    v.e_ins = e_ins; v.e_z = e_z;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [15:0] act,
                     input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic idle();
    read_en = 4'd0; write_en = '0; inc_en = '0;
    clr_en = '0; alu_op = 3'd0;
  endtask

  task automatic apply(input vec_t v, input int i);
    string s;
    @(negedge clk);
    read_en = v.re; write_en = v.we; inc_en = v.inc;
    clr_en = v.clr; alu_op = v.op;
    im_rdata = v.im; dm_rdata = v.dm;
    @(posedge clk);
    #1;
    idle();
    read_en = v.obs;
    #1;
    s = $sformatf("v%0d", i);
    chk({s, ".bus"}, bus, v.e_bus);
    chk({s, ".pc"}, im_addr, v.e_pc);
    chk({s, ".ar"}, dm_addr, v.e_ar);
    chk({s, ".ins"}, {10'd0, instruction}, {10'd0, v.e_ins});
    chk({s, ".z"}, z, {15'd0, v.e_z});
  endtask

  initial begin
    rst_n = 1'b0;
    idle();
    im_rdata = '0; dm_rdata = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst.pc", im_addr, 16'h0000);
    chk("rst.z", z, 16'h0001);
    @(negedge clk);
    rst_n = 1'b1;

    //     re     we           inc    clr    op    im        dm        obs    bus       pc        ar        ins    z
    vq.push_back(mk(4'd13, b(1),  0,     0,     3'd0, 16'h0003, 16'h0000, 4'd1,  16'h0003, 16'h0003, 16'h0000, 6'h00, 1));
    vq.push_back(mk(4'd13, b(3),  0,     0,     3'd0, 16'h0285, 16'h0000, 4'd4,  16'h000A, 16'h0003, 16'h0000, 6'h05, 1));
    vq.push_back(mk(4'd13, b(3),  0,     0,     3'd0, 16'h0405, 16'h0000, 4'd4,  16'h0010, 16'h0003, 16'h0000, 6'h05, 1));
    vq.push_back(mk(4'd4,  b(1),  b(1),  0,     3'd0, 16'h0000, 16'h0000, 4'd1,  16'h0010, 16'h0010, 16'h0000, 6'h05, 1));
    vq.push_back(mk(4'd13, b(4),  0,     0,     3'd0, 16'hFFFF, 16'h0000, 4'd5,  16'hFFFF, 16'h0010, 16'h0000, 6'h05, 0));
    vq.push_back(mk(4'd13, b(5),  0,     0,     3'd0, 16'h0002, 16'h0000, 4'd6,  16'h0002, 16'h0010, 16'h0000, 6'h05, 0));
    vq.push_back(mk(4'd0,  b(12), 0,     0,     3'd1, 16'h0000, 16'h0000, 4'd5,  16'h0001, 16'h0010, 16'h0000, 6'h05, 0));
    vq.push_back(mk(4'd13, b(4),  0,     0,     3'd0, 16'hFFFF, 16'h0000, 4'd5,  16'hFFFF, 16'h0010, 16'h0000, 6'h05, 0));
    vq.push_back(mk(4'd0,  b(12), 0,     0,     3'd2, 16'h0000, 16'h0000, 4'd5,  16'hFFFD, 16'h0010, 16'h0000, 6'h05, 0));
    vq.push_back(mk(4'd13, b(4),  0,     0,     3'd0, 16'hFFFF, 16'h0000, 4'd5,  16'hFFFF, 16'h0010, 16'h0000, 6'h05, 0));
    vq.push_back(mk(4'd0,  b(12), 0,     0,     3'd3, 16'h0000, 16'h0000, 4'd5,  16'hFFFE, 16'h0010, 16'h0000, 6'h05, 0));
    vq.push_back(mk(4'd13, b(4),  0,     0,     3'd0, 16'hFFFF, 16'h0000, 4'd5,  16'hFFFF, 16'h0010, 16'h0000, 6'h05, 0));
    vq.push_back(mk(4'd0,  b(12), 0,     0,     3'd4, 16'h0000, 16'h0000, 4'd5,  16'hFFFE, 16'h0010, 16'h0000, 6'h05, 0));
    vq.push_back(mk(4'd13, b(4),  0,     0,     3'd0, 16'hFFFF, 16'h0000, 4'd5,  16'hFFFF, 16'h0010, 16'h0000, 6'h05, 0));
    vq.push_back(mk(4'd0,  b(12), 0,     0,     3'd6, 16'h0000, 16'h0000, 4'd5,  16'hFFFF, 16'h0010, 16'h0000, 6'h05, 0));
    vq.push_back(mk(4'd0,  0,     b(4),  0,     3'd0, 16'h0000, 16'h0000, 4'd5,  16'h0000, 16'h0010, 16'h0000, 6'h05, 1));
    vq.push_back(mk(4'd13, b(4),  0,     0,     3'd0, 16'h0040, 16'h0000, 4'd5,  16'h0040, 16'h0010, 16'h0000, 6'h05, 0));
    vq.push_back(mk(4'd5,  b(2),  0,     0,     3'd0, 16'h0000, 16'h0000, 4'd2,  16'h0040, 16'h0010, 16'h0040, 6'h05, 0));
    vq.push_back(mk(4'd12, b(4),  0,     0,     3'd0, 16'h0000, 16'h1234, 4'd5,  16'h1234, 16'h0010, 16'h0040, 6'h05, 0));
    vq.push_back(mk(4'd0,  b(12), b(4),  b(4),  3'd1, 16'h0000, 16'h0000, 4'd5,  16'h0000, 16'h0010, 16'h0040, 6'h05, 1));
    vq.push_back(mk(4'd13, b(1),  0,     b(1),  3'd0, 16'h0055, 16'h0000, 4'd1,  16'h0000, 16'h0000, 16'h0040, 6'h05, 1));
    vq.push_back(mk(4'd0,  0,     b(1),  0,     3'd0, 16'h0000, 16'h0000, 4'd1,  16'h0001, 16'h0001, 16'h0040, 6'h05, 1));
    vq.push_back(mk(4'd13, b(4),  0,     0,     3'd0, 16'hBEEF, 16'h0000, 4'd5,  16'hBEEF, 16'h0001, 16'h0040, 6'h05, 0));
    vq.push_back(mk(4'd5,  b(10), 0,     0,     3'd0, 16'h0000, 16'h0000, 4'd7,  16'hBEEF, 16'h0001, 16'h0040, 6'h05, 0));
    vq.push_back(mk(4'd0,  0,     0,     b(4),  3'd0, 16'h0000, 16'h0000, 4'd5,  16'h0000, 16'h0001, 16'h0040, 6'h05, 1));
    vq.push_back(mk(4'd7,  b(4),  0,     0,     3'd0, 16'h0000, 16'h0000, 4'd5,  16'hBEEF, 16'h0001, 16'h0040, 6'h05, 0));
    vq.push_back(mk(4'd5,  b(9),  0,     0,     3'd0, 16'h0000, 16'h0000, 4'd8,  16'hBEEF, 16'h0001, 16'h0040, 6'h05, 0));
    vq.push_back(mk(4'd5,  b(8),  0,     0,     3'd0, 16'h0000, 16'h0000, 4'd9,  16'hBEEF, 16'h0001, 16'h0040, 6'h05, 0));
    vq.push_back(mk(4'd5,  b(7),  0,     0,     3'd0, 16'h0000, 16'h0000, 4'd10, 16'hBEEF, 16'h0001, 16'h0040, 6'h05, 0));
    vq.push_back(mk(4'd3,  b(4),  0,     0,     3'd0, 16'h7777, 16'h7777, 4'd11, 16'h0000, 16'h0001, 16'h0040, 6'h05, 1));
    vq.push_back(mk(4'd0,  0,     0,     b(2),  3'd0, 16'h0000, 16'h0000, 4'd2,  16'h0000, 16'h0001, 16'h0000, 6'h05, 1));
    vq.push_back(mk(4'd13, b(1),  0,     0,     3'd0, 16'hFFFF, 16'h0000, 4'd1,  16'hFFFF, 16'hFFFF, 16'h0000, 6'h05, 1));
    vq.push_back(mk(4'd0,  0,     b(1),  0,     3'd0, 16'h0000, 16'h0000, 4'd1,  16'h0000, 16'h0000, 16'h0000, 6'h05, 1));
    vq.push_back(mk(4'd0,  0,     0,     0,     3'd0, 16'h0000, 16'h0000, 4'd4,  16'h0010, 16'h0000, 16'h0000, 6'h05, 1));

    for (int i = 0; i < vq.size(); i++) apply(vq[i], i);

    // Memory write: AC=0040 -> AR, then DM write strobe.
    apply(mk(4'd13, b(4), 0, 0, 3'd0, 16'h0040, 16'h0000, 4'd5,
             16'h0040, 16'h0000, 16'h0000, 6'h05, 0), 100);
    apply(mk(4'd5, b(2), 0, 0, 3'd0, 16'h0000, 16'h0000, 4'd2,
             16'h0040, 16'h0000, 16'h0040, 6'h05, 0), 101);
    @(negedge clk);
    read_en = 4'd5; write_en = b(11);
    #1;
    chk("mem.we", {15'd0, dm_we}, 16'h0001);
    chk("mem.addr", dm_addr, 16'h0040);
    chk("mem.wdata", dm_wdata, 16'h0040);
    @(posedge clk);
    #1;
    idle();
    #1;
    chk("mem.we_off", {15'd0, dm_we}, 16'h0000);

    // Reset mid-operation with every strobe active.
    @(negedge clk);
    read_en = 4'd13; im_rdata = 16'h1234;
    write_en = 16'hFFFF; inc_en = 16'hFFFF; alu_op = 3'd1;
    #2;
    rst_n = 1'b0;
    #1;
    chk("rst2.pc", im_addr, 16'h0000);
    chk("rst2.ar", dm_addr, 16'h0000);
    @(posedge clk);
    #1;
    chk("rst2.pc_hold", im_addr, 16'h0000);
    chk("rst2.ins", {10'd0, instruction}, 16'h0000);
    chk("rst2.z", z, 16'h0001);
    chk("rst2.dm_we", {15'd0, dm_we}, 16'h0001);
    @(negedge clk);
    idle();
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    read_en = 4'd5;
    #1;
    chk("post.ac", bus, 16'h0000);
    read_en = 4'd7;
    #1;
    chk("post.r1", bus, 16'h0000);
    read_en = 4'd4;
    #1;
    chk("post.ir", bus, 16'h0000);
    chk("post.pc", im_addr, 16'h0000);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
